rx_data_sampler: RTL and testbench

RX_DATA_SAMPLER -- requirements
Module: rx_data_sampler

---
 rtl/rx_data_sampler.sv | 131 +++++++++++++
 tb/tb_rx_data_sampler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_data_sampler.sv
// rtl/rx_data_sampler.sv - oversampling serial receiver front end; RX_SAMPLER_MAJORITY_EN selects 2-of-3 bit voting
module rx_data_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  enable,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [3:0]            bit_cnt,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  frame_done,
    output logic                  start_glitch
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_par_en;
    logic                  r_s1;
`ifdef RX_SAMPLER_MAJORITY_EN
    logic                  r_s0;
`endif

    logic                  w_rx_s;
    logic                  w_decided;
    logic                  w_wrap;
    logic                  w_last_bit;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_pt_lo;
    logic [PRESCALE_W-1:0] w_pt_hi;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic [3:0]            w_last_idx;

    assign w_rx_s      = r_sync2;
    assign w_half      = r_presc >> 1;
    assign w_pt_lo     = w_half - ONE;
    assign w_pt_hi     = w_half + ONE;
    assign w_last_edge = r_presc - ONE;
    assign w_last_idx  = r_par_en ? 4'd11 : 4'd10;
    // Inequalities keep an illegal latched Prescale from wedging the counters.
    assign w_wrap      = (edge_cnt >= w_last_edge);
    assign w_last_bit  = (bit_cnt >= w_last_idx);

`ifdef RX_SAMPLER_MAJORITY_EN
    assign w_decided = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
`else
    assign w_decided = r_s1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_par_en     <= 1'b0;
            r_s1         <= 1'b1;
`ifdef RX_SAMPLER_MAJORITY_EN
            r_s0         <= 1'b1;
`endif
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            bit_cnt      <= 4'd0;
            edge_cnt     <= '0;
            frame_done   <= 1'b0;
            start_glitch <= 1'b0;
        end else begin
            r_sync1      <= RX_IN;
            r_sync2      <= r_sync1;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            start_glitch <= 1'b0;
            if (!enable) begin
                r_state  <= S_IDLE;
                bit_cnt  <= 4'd0;
                edge_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        bit_cnt  <= 4'd0;
                        edge_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state  <= S_ACTIVE;
                            bit_cnt  <= 4'd1;
                            r_presc  <= Prescale;
                            r_par_en <= PAR_EN;
                        end
                    end
                    S_ACTIVE: begin
`ifdef RX_SAMPLER_MAJORITY_EN
                        if (edge_cnt == w_pt_lo) r_s0 <= w_rx_s;
`endif
                        if (edge_cnt == w_half) r_s1 <= w_rx_s;
                        if (w_wrap) begin
                            edge_cnt <= '0;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else begin
                            edge_cnt <= edge_cnt + ONE;
                        end
                        // Third sample point is the live rx_s, so the decision lands one cycle later.
                        if (edge_cnt == w_pt_hi) begin
                            sampled_bit  <= w_decided;
                            sample_valid <= 1'b1;
                            if (bit_cnt == 4'd1 && w_decided) begin
                                start_glitch <= 1'b1;
                                r_state      <= S_IDLE;
                                bit_cnt      <= 4'd0;
                                edge_cnt     <= '0;
                            end
                        end
                        if (w_wrap && w_last_bit) begin
                            r_state    <= S_IDLE;
                            frame_done <= 1'b1;
                            bit_cnt    <= 4'd0;
                            edge_cnt   <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_data_sampler.sv
// tb/tb_rx_data_sampler.sv - randomized bench for rx_data_sampler against a waveform-level model
module tb_rx_data_sampler;
    localparam int N = 16384;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       enable = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       sampled_bit;
    logic       sample_valid;
    logic [3:0] bit_cnt;
    logic [5:0] edge_cnt;
    logic       frame_done;
    logic       start_glitch;

    rx_data_sampler #(.PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .enable(enable), .PAR_EN(PAR_EN),
        .Prescale(Prescale), .sampled_bit(sampled_bit), .sample_valid(sample_valid),
        .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .frame_done(frame_done),
        .start_glitch(start_glitch)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic       line   [N];
    logic       exp_sv [N];
    logic       exp_fd [N];
    logic       exp_sg [N];
    logic       exp_val[N];
    logic [3:0] exp_bc [N];
    logic [5:0] exp_ec [N];
    int idle_from = 0;
    int last_a = 0;
    bit scr_en = 0;
    logic m_sb = 1'b1;
    int sv_cnt = 0, fd_cnt = 0, sg_cnt = 0;
    logic act_bits[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (cyc < N) begin
            if (RST) m_sb = 1'b1;
            else if (exp_sv[cyc]) m_sb = exp_val[cyc];
            chk("sample_valid", 32'(sample_valid), 32'(exp_sv[cyc]));
            chk("frame_done", 32'(frame_done), 32'(exp_fd[cyc]));
            chk("start_glitch", 32'(start_glitch), 32'(exp_sg[cyc]));
            chk("bit_cnt", 32'(bit_cnt), 32'(exp_bc[cyc]));
            chk("edge_cnt", 32'(edge_cnt), 32'(exp_ec[cyc]));
            chk("sampled_bit", 32'(sampled_bit), 32'(m_sb));
        end
        if (sample_valid) begin
            sv_cnt++;
            act_bits[bit_cnt] = sampled_bit;
        end
        if (frame_done) fd_cnt++;
        if (start_glitch) sg_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic trunc(input int c);
        for (int t = c; t < N; t++) begin
            exp_sv[t] = 0; exp_fd[t] = 0; exp_sg[t] = 0; exp_val[t] = 0;
            exp_bc[t] = 0; exp_ec[t] = 0;
        end
    endtask

    task automatic put(input int c, input int b, input int e);
        if (c < N) begin
            exp_bc[c] = 4'(b);
            exp_ec[c] = 6'(e);
        end
    endtask

    // Line value seen at a sample point is the value driven two cycles earlier.
    task automatic fill_frame(input int k, input int p, input bit par);
        int last, a, cs;
        logic dec;
        last = par ? 11 : 10;
        a = ((k + 2 > idle_from) ? k + 2 : idle_from) + 1;
        last_a = a;
        for (int b = 1; b <= last; b++) begin
            cs = a + (b - 1) * p + p / 2 - 1;
`ifdef RX_SAMPLER_MAJORITY_EN
            dec = (int'(line[cs-2]) + int'(line[cs-1]) + int'(line[cs])) >= 2;
`else
            dec = line[cs-1];
`endif
            if (b == 1 && dec) begin
                for (int e = 0; e <= p / 2 + 1; e++) put(a + e, 1, e);
                exp_sv[cs+3] = 1; exp_sg[cs+3] = 1; exp_val[cs+3] = dec;
                idle_from = cs + 3;
                return;
            end
            for (int e = 0; e < p; e++) put(a + (b - 1) * p + e, b, e);
            exp_sv[cs+3] = 1; exp_val[cs+3] = dec;
        end
        exp_fd[a + last * p] = 1;
        idle_from = a + last * p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            RX_IN = 1'b1;
            line[cyc] = 1'b1;
        end
    endtask

    task automatic run_frame(input int p, input bit par, input logic [7:0] data, input logic pbit,
                             input int spike_bit, input int spike_off, input int stop_rel);
        int k, last, n;
        logic bv;
        last = par ? 11 : 10;
        n = last * p;
        tick();
        k = cyc;
        Prescale = 6'(p);
        PAR_EN = par;
        for (int b = 1; b <= last; b++) begin
            if (b == 1) bv = 1'b0;
            else if (b <= 9) bv = data[b-2];
            else if (b == 10 && par) bv = pbit;
            else bv = 1'b1;
            for (int i = 0; i < p; i++) line[k + (b - 1) * p + i] = bv;
        end
        if (spike_bit > 0) line[k + (spike_bit - 1) * p + spike_off] = ~line[k + (spike_bit - 1) * p + spike_off];
        fill_frame(k, p, par);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            RX_IN = line[k + i];
            if (scr_en && cyc >= last_a && $urandom_range(0, 7) == 0) begin
                Prescale = 6'($urandom_range(0, 63));
                PAR_EN = 1'($urandom_range(0, 1));
            end
            if (stop_rel >= 0 && cyc == last_a + stop_rel) break;
        end
    endtask

    task automatic clr_mon();
        sv_cnt = 0; fd_cnt = 0; sg_cnt = 0;
        for (int i = 0; i < 16; i++) act_bits[i] = 1'bx;
    endtask

    task automatic chk_bits(input string nm, input logic [7:0] data);
        logic [7:0] d;
        d = data;
        chk({nm, "_start"}, 32'(act_bits[1]), 32'd0);
        for (int i = 0; i < 8; i++) chk({nm, "_data"}, 32'(act_bits[i+2]), 32'(d[i]));
    endtask

    initial begin
        int p, gap, prev_gap, sb, so, snap;
        bit par;
        logic [7:0] data;
        for (int i = 0; i < N; i++) begin
            line[i] = 1; exp_sv[i] = 0; exp_fd[i] = 0; exp_sg[i] = 0; exp_val[i] = 0;
            exp_bc[i] = 0; exp_ec[i] = 0;
        end
        clr_mon();
        @(negedge CLK);
        chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        tick(); tick();
        RST = 1'b0;
        idle_from = cyc;
        idle(5);

        // Prescale 8, no parity, 0xA5
        clr_mon();
        run_frame(8, 0, 8'hA5, 1'b0, 0, 0, -1);
        idle(8);
        chk("a5_pulses", 32'(sv_cnt), 32'd10);
        chk("a5_done", 32'(fd_cnt), 32'd1);
        chk_bits("a5", 8'hA5);
        chk("a5_stop", 32'(act_bits[10]), 32'd1);

        // Prescale 16, parity, 0x3C
        clr_mon();
        run_frame(16, 1, 8'h3C, 1'b0, 0, 0, -1);
        idle(8);
        chk("3c_pulses", 32'(sv_cnt), 32'd11);
        chk("3c_done", 32'(fd_cnt), 32'd1);
        chk_bits("3c", 8'h3C);
        chk("3c_parity", 32'(act_bits[10]), 32'd0);
        chk("3c_stop", 32'(act_bits[11]), 32'd1);

        // False start: three low cycles
        clr_mon();
        tick();
        Prescale = 6'd8; PAR_EN = 1'b0;
        for (int i = 0; i < 24; i++) line[cyc + i] = (i >= 3);
        fill_frame(cyc, 8, 0);
        RX_IN = 1'b0;
        for (int i = 1; i < 24; i++) begin
            tick();
            RX_IN = line[cyc];
        end
        idle(4);
        chk("glitch_pulse", 32'(sg_cnt), 32'd1);
        chk("glitch_valid", 32'(sv_cnt), 32'd1);
        chk("glitch_no_done", 32'(fd_cnt), 32'd0);
        chk("glitch_idle_bit_cnt", 32'(bit_cnt), 32'd0);

        // One-cycle spike on the centre sample of data bit 1 (bit_cnt 3)
        clr_mon();
        run_frame(8, 0, 8'hFF, 1'b0, 3, 8 / 2 + 1, -1);
        idle(8);
`ifdef RX_SAMPLER_MAJORITY_EN
        chk("spike_bit", 32'(act_bits[3]), 32'd1);
`else
        chk("spike_bit", 32'(act_bits[3]), 32'd0);
`endif
        chk("spike_done", 32'(fd_cnt), 32'd1);

        // Reset pulse at bit_cnt 5, then 0x55
        clr_mon();
        run_frame(8, 0, 8'h0F, 1'b0, 0, 0, 4 * 8 + 3);
        RST = 1'b1;
        trunc(cyc);
        idle(3);
        RST = 1'b0;
        idle_from = cyc;
        idle(3);
        chk("rst_mid_no_done", 32'(fd_cnt), 32'd0);
        clr_mon();
        run_frame(8, 0, 8'h55, 1'b0, 0, 0, -1);
        idle(8);
        chk_bits("55", 8'h55);
        chk("55_done", 32'(fd_cnt), 32'd1);

        // enable dropped at bit_cnt 4
        clr_mon();
        run_frame(8, 0, 8'h33, 1'b0, 0, 0, 3 * 8 + 2);
        enable = 1'b0;
        trunc(cyc + 1);
        snap = sv_cnt;
        idle(10);
        chk("en_no_valid", 32'(sv_cnt - snap), 32'd0);
        chk("en_no_done", 32'(fd_cnt), 32'd0);
        enable = 1'b1;
        idle_from = cyc;
        idle(4);

        // Randomized frames with mid-frame config scrambling and occasional spikes
        scr_en = 1;
        prev_gap = 1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 2))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            par = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 0;
            so = int'($urandom_range(0, p - 1));
            run_frame(p, par, data, 1'($urandom_range(0, 1)), sb, so, -1);
            gap = (prev_gap == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
            if (gap > 0) idle(gap);
            prev_gap = gap;
        end
        scr_en = 0;
        idle(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
